// File: rtl/msrv32_instr_fetch_if.sv
// Bus bundle for the instruction fetch unit. It carries the PC intake, the
// instruction-memory request/response channel and the decode-side output.
//   slave  : view used by the fetch unit itself
//   master : view used by whatever surrounds it (PC register, memory, decode)
interface msrv32_instr_fetch_if;
    logic [31:0] pc_in;
    logic        pc_valid_in;
    logic        fetch_ready_out;
    logic        flush_in;
    logic        imem_req_valid_out;
    logic        imem_req_ready_in;
    logic [31:0] imem_addr_out;
    logic        imem_rsp_valid_in;
    logic [31:0] imem_rsp_data_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_misaligned_out;

    modport slave (
        input  pc_in, pc_valid_in, flush_in, imem_req_ready_in,
               imem_rsp_valid_in, imem_rsp_data_in, instr_ready_in,
        output fetch_ready_out, imem_req_valid_out, imem_addr_out,
               instr_valid_out, instr_out, instr_pc_out, instr_misaligned_out
    );

    modport master (
        output pc_in, pc_valid_in, flush_in, imem_req_ready_in,
               imem_rsp_valid_in, imem_rsp_data_in, instr_ready_in,
        input  fetch_ready_out, imem_req_valid_out, imem_addr_out,
               instr_valid_out, instr_out, instr_pc_out, instr_misaligned_out
    );
endinterface

// File: rtl/msrv32_instr_fetch.sv
// Instruction fetch unit: accepts PCs, issues in-order word fetches, pairs
// each returned word with its PC and offers it to decode. A flush drops all
// buffered entries and marks every in-flight fetch for discard.
// Optional feature macro: MSRV32_IF_MISALIGN_CHK_EN (misaligned-PC fault
// detection; faulting entries carry NOP_INSTR and a misaligned flag).
module msrv32_instr_fetch #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_n_in,
    msrv32_instr_fetch_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    // occupancy counters and FIFO pointers
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;

    // tag FIFO: PC and fault flag of each live in-flight fetch
    logic [31:0] tag_pc_mem   [DEPTH];
    logic        tag_flag_mem [DEPTH];
    // output buffer: completed {pc, word, flag} entries awaiting decode
    logic [31:0] buf_pc_mem    [DEPTH];
    logic [31:0] buf_instr_mem [DEPTH];
    logic        buf_flag_mem  [DEPTH];

    logic credit_ok, issue, rsp_take, rsp_keep, pop, issue_flag, head_valid;

    // in-flight plus buffered entries must stay below DEPTH so the buffer never overflows
    assign credit_ok = ({1'b0, out_cnt_q} + {1'b0, buf_cnt_q}) < DEPTH_W;

    assign bus.imem_req_valid_out = bus.pc_valid_in & credit_ok & ~bus.flush_in;
    assign bus.fetch_ready_out    = bus.imem_req_ready_in & credit_ok & ~bus.flush_in;
    assign bus.imem_addr_out      = {bus.pc_in[31:2], 2'b00};

`ifdef MSRV32_IF_MISALIGN_CHK_EN
    assign issue_flag = |bus.pc_in[1:0];
`else
    // no fault detection: flag is constant 0, so the misaligned output is tied low
    assign issue_flag = 1'b0;
`endif

    assign issue    = bus.pc_valid_in & bus.fetch_ready_out;
    // a response with nothing outstanding is a protocol error and is ignored
    assign rsp_take = bus.imem_rsp_valid_in & (out_cnt_q != '0);
    assign rsp_keep = rsp_take & (drop_cnt_q == '0) & ~bus.flush_in;

    assign head_valid = (buf_cnt_q != '0);
    assign pop        = head_valid & bus.instr_ready_in & ~bus.flush_in;

    assign bus.instr_valid_out      = head_valid;
    assign bus.instr_out            = head_valid ? buf_instr_mem[buf_rd_q] : 32'h0;
    assign bus.instr_pc_out         = head_valid ? buf_pc_mem[buf_rd_q]    : 32'h0;
    assign bus.instr_misaligned_out = head_valid & buf_flag_mem[buf_rd_q];

    // next-state for counters and pointers; flush clears both FIFOs and
    // reloads the drop count with what remains outstanding after this cycle
    always_comb begin
        out_cnt_d  = out_cnt_q + CW'(issue) - CW'(rsp_take);
        drop_cnt_d = drop_cnt_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;
        buf_cnt_d  = buf_cnt_q;
        if (bus.flush_in) begin
            drop_cnt_d = out_cnt_d;
            tag_wr_d   = '0;
            tag_rd_d   = '0;
            buf_wr_d   = '0;
            buf_rd_d   = '0;
            buf_cnt_d  = '0;
        end else begin
            if (rsp_take && drop_cnt_q != '0)
                drop_cnt_d = drop_cnt_q - CW'(1);
            if (issue)
                tag_wr_d = tag_wr_q + PW'(1);
            if (rsp_keep) begin
                tag_rd_d = tag_rd_q + PW'(1);
                buf_wr_d = buf_wr_q + PW'(1);
            end
            if (pop)
                buf_rd_d = buf_rd_q + PW'(1);
            buf_cnt_d = buf_cnt_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    // control state register with synchronous active-low reset
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            buf_cnt_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            buf_cnt_q  <= buf_cnt_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
        end
    end

    // storage writes; contents need no reset since occupancy gates every read
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (issue) begin
            tag_pc_mem[tag_wr_q]   <= bus.pc_in;
            tag_flag_mem[tag_wr_q] <= issue_flag;
        end
        if (rsp_keep) begin
            buf_pc_mem[buf_wr_q]    <= tag_pc_mem[tag_rd_q];
            buf_flag_mem[buf_wr_q]  <= tag_flag_mem[tag_rd_q];
            buf_instr_mem[buf_wr_q] <= tag_flag_mem[tag_rd_q] ? NOP_INSTR : bus.imem_rsp_data_in;
        end
    end
endmodule

// File: tb/tb_msrv32_instr_fetch.sv
// Directed testbench for msrv32_instr_fetch (DEPTH=2). Inputs change 1 ns
// after each rising edge; outputs are sampled 1 ns after inputs settle.
module tb_msrv32_instr_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    msrv32_instr_fetch_if bus();

    msrv32_instr_fetch #(.DEPTH(2), .NOP_INSTR(32'h0000_0013)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .bus                    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.pc_in = 32'h0; bus.pc_valid_in = 1'b0; bus.flush_in = 1'b0;
        bus.imem_req_ready_in = 1'b1; bus.imem_rsp_valid_in = 1'b0;
        bus.imem_rsp_data_in = 32'h0; bus.instr_ready_in = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        n_chk++; if (bus.instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid_out); end
        n_chk++; if (bus.instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr_out: got %h want 0", bus.instr_out); end
        n_chk++; if (bus.instr_pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc_out); end
        n_chk++; if (bus.instr_misaligned_out !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b want 0", bus.instr_misaligned_out); end
        rst_n = 1'b1;
        #1;
        n_chk++; if (bus.fetch_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready: got %b want 1", bus.fetch_ready_out); end
        n_chk++; if (bus.imem_req_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid_out); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        bus.instr_ready_in = 1'b1;
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h0;
        #1;
        n_chk++; if (bus.imem_req_valid_out !== 1'b1) begin n_fail++; $display("FAIL stream_req_valid: got %b want 1", bus.imem_req_valid_out); end
        n_chk++; if (bus.imem_addr_out !== 32'h0) begin n_fail++; $display("FAIL stream_addr0: got %h want 0", bus.imem_addr_out); end
        tick();
        bus.pc_in = 32'h4;
        #1;
        n_chk++; if (bus.imem_addr_out !== 32'h4) begin n_fail++; $display("FAIL stream_addr4: got %h want 4", bus.imem_addr_out); end
        n_chk++; if (bus.fetch_ready_out !== 1'b1) begin n_fail++; $display("FAIL stream_ready2: got %b want 1", bus.fetch_ready_out); end
        tick();
        bus.pc_valid_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'hAAAA0001;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL stream_latency: got %b want 0", bus.instr_valid_out); end
        n_chk++; if (bus.fetch_ready_out !== 1'b0) begin n_fail++; $display("FAIL stream_credit_full: got %b want 0", bus.fetch_ready_out); end
        tick();
        bus.imem_rsp_data_in = 32'hAAAA0002;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b1 || bus.instr_out !== 32'hAAAA0001 || bus.instr_pc_out !== 32'h0)
            begin n_fail++; $display("FAIL stream_first: got v=%b %h@%h want 1 aaaa0001@0", bus.instr_valid_out, bus.instr_out, bus.instr_pc_out); end
        tick();
        bus.imem_rsp_valid_in = 1'b0;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b1 || bus.instr_out !== 32'hAAAA0002 || bus.instr_pc_out !== 32'h4)
            begin n_fail++; $display("FAIL stream_second: got v=%b %h@%h want 1 aaaa0002@4", bus.instr_valid_out, bus.instr_out, bus.instr_pc_out); end
        tick();
        n_chk++; if (bus.instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", bus.instr_valid_out); end
        $display("test_stream done");
    endtask

    task automatic test_credit();
        bus.instr_ready_in = 1'b0;
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h10; tick();
        bus.pc_in = 32'h14; tick();
        bus.pc_valid_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h11111111; tick();
        bus.imem_rsp_data_in = 32'h22222222; tick();
        bus.imem_rsp_valid_in = 1'b0;
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h8;
        #1;
        n_chk++; if (bus.fetch_ready_out !== 1'b0 || bus.imem_req_valid_out !== 1'b0)
            begin n_fail++; $display("FAIL credit_block: got rdy=%b req=%b want 0 0", bus.fetch_ready_out, bus.imem_req_valid_out); end
        tick();
        n_chk++; if (bus.fetch_ready_out !== 1'b0) begin n_fail++; $display("FAIL credit_hold: got %b want 0", bus.fetch_ready_out); end
        bus.instr_ready_in = 1'b1;
        #1;
        n_chk++; if (bus.instr_pc_out !== 32'h10 || bus.instr_out !== 32'h11111111)
            begin n_fail++; $display("FAIL credit_head0: got %h@%h want 11111111@10", bus.instr_out, bus.instr_pc_out); end
        tick();
        bus.instr_ready_in = 1'b0;
        #1;
        n_chk++; if (bus.fetch_ready_out !== 1'b1) begin n_fail++; $display("FAIL credit_release: got %b want 1", bus.fetch_ready_out); end
        tick();
        bus.pc_valid_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h33333333; tick();
        bus.imem_rsp_valid_in = 1'b0; bus.instr_ready_in = 1'b1;
        #1;
        n_chk++; if (bus.instr_pc_out !== 32'h14 || bus.instr_out !== 32'h22222222)
            begin n_fail++; $display("FAIL credit_head1: got %h@%h want 22222222@14", bus.instr_out, bus.instr_pc_out); end
        tick();
        n_chk++; if (bus.instr_valid_out !== 1'b1 || bus.instr_pc_out !== 32'h8 || bus.instr_out !== 32'h33333333)
            begin n_fail++; $display("FAIL credit_third: got v=%b %h@%h want 1 33333333@8", bus.instr_valid_out, bus.instr_out, bus.instr_pc_out); end
        tick();
        n_chk++; if (bus.instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL credit_drained: got %b want 0", bus.instr_valid_out); end
        $display("test_credit done");
    endtask

    task automatic test_flush();
        bus.instr_ready_in = 1'b1;
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h20; tick();
        bus.pc_in = 32'h24; tick();
        bus.pc_in = 32'h100; bus.flush_in = 1'b1;
        #1;
        n_chk++; if (bus.imem_req_valid_out !== 1'b0 || bus.fetch_ready_out !== 1'b0)
            begin n_fail++; $display("FAIL flush_no_issue: got req=%b rdy=%b want 0 0", bus.imem_req_valid_out, bus.fetch_ready_out); end
        tick();
        bus.flush_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'hDEAD0001;
        #1;
        n_chk++; if (bus.fetch_ready_out !== 1'b0) begin n_fail++; $display("FAIL flush_credit: got %b want 0", bus.fetch_ready_out); end
        tick();
        bus.imem_rsp_data_in = 32'hDEAD0002;
        #1;
        n_chk++; if (bus.fetch_ready_out !== 1'b1 || bus.instr_valid_out !== 1'b0)
            begin n_fail++; $display("FAIL flush_drop1: got rdy=%b v=%b want 1 0", bus.fetch_ready_out, bus.instr_valid_out); end
        tick();
        bus.pc_valid_in = 1'b0; bus.imem_rsp_data_in = 32'hBBBB0100;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_drop2: got %b want 0", bus.instr_valid_out); end
        tick();
        bus.imem_rsp_valid_in = 1'b0;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b1 || bus.instr_out !== 32'hBBBB0100 || bus.instr_pc_out !== 32'h100)
            begin n_fail++; $display("FAIL flush_new: got v=%b %h@%h want 1 bbbb0100@100", bus.instr_valid_out, bus.instr_out, bus.instr_pc_out); end
        tick();
        n_chk++; if (bus.instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_drained: got %b want 0", bus.instr_valid_out); end
        $display("test_flush done");
    endtask

    task automatic test_flush_with_rsp();
        bus.instr_ready_in = 1'b1;
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h30; tick();
        bus.pc_in = 32'h34; tick();
        bus.pc_valid_in = 1'b0; bus.flush_in = 1'b1;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'hC0000001; tick();
        bus.flush_in = 1'b0; bus.imem_rsp_valid_in = 1'b0;
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h200;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b0 || bus.fetch_ready_out !== 1'b1)
            begin n_fail++; $display("FAIL fr_after: got v=%b rdy=%b want 0 1", bus.instr_valid_out, bus.fetch_ready_out); end
        tick();
        bus.pc_valid_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'hC0000002; tick();
        bus.imem_rsp_data_in = 32'hC0000200;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b0) begin n_fail++; $display("FAIL fr_dropped: got %b want 0", bus.instr_valid_out); end
        tick();
        bus.imem_rsp_valid_in = 1'b0;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b1 || bus.instr_out !== 32'hC0000200 || bus.instr_pc_out !== 32'h200)
            begin n_fail++; $display("FAIL fr_kept: got v=%b %h@%h want 1 c0000200@200", bus.instr_valid_out, bus.instr_out, bus.instr_pc_out); end
        tick();
        $display("test_flush_with_rsp done");
    endtask

    task automatic test_flush_buffered();
        bus.instr_ready_in = 1'b0;
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h40; tick();
        bus.pc_valid_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h00004040; tick();
        bus.imem_rsp_valid_in = 1'b0;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b1) begin n_fail++; $display("FAIL fb_buffered: got %b want 1", bus.instr_valid_out); end
        bus.flush_in = 1'b1; tick();
        bus.flush_in = 1'b0;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b0 || bus.fetch_ready_out !== 1'b1)
            begin n_fail++; $display("FAIL fb_cleared: got v=%b rdy=%b want 0 1", bus.instr_valid_out, bus.fetch_ready_out); end
        // stray response with nothing outstanding must be ignored
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'hFFFF0000; tick();
        bus.imem_rsp_valid_in = 1'b0;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b0 || bus.fetch_ready_out !== 1'b1)
            begin n_fail++; $display("FAIL stray_rsp: got v=%b rdy=%b want 0 1", bus.instr_valid_out, bus.fetch_ready_out); end
        $display("test_flush_buffered done");
    endtask

    task automatic test_misalign();
        bus.instr_ready_in = 1'b0;
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h6;
        #1;
        n_chk++; if (bus.imem_addr_out !== 32'h4) begin n_fail++; $display("FAIL mis_addr: got %h want 4", bus.imem_addr_out); end
        tick();
        bus.pc_valid_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'hCAFE0006; tick();
        bus.imem_rsp_valid_in = 1'b0;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b1 || bus.instr_pc_out !== 32'h6)
            begin n_fail++; $display("FAIL mis_pc: got v=%b pc=%h want 1 6", bus.instr_valid_out, bus.instr_pc_out); end
`ifdef MSRV32_IF_MISALIGN_CHK_EN
        n_chk++; if (bus.instr_out !== 32'h00000013 || bus.instr_misaligned_out !== 1'b1)
            begin n_fail++; $display("FAIL mis_fault: got %h m=%b want 00000013 1", bus.instr_out, bus.instr_misaligned_out); end
`else
        n_chk++; if (bus.instr_out !== 32'hCAFE0006 || bus.instr_misaligned_out !== 1'b0)
            begin n_fail++; $display("FAIL mis_nofault: got %h m=%b want cafe0006 0", bus.instr_out, bus.instr_misaligned_out); end
`endif
        bus.instr_ready_in = 1'b1; tick();
        bus.instr_ready_in = 1'b0;
        $display("test_misalign done");
    endtask

    task automatic test_reset_mid();
        bus.pc_valid_in = 1'b1; bus.pc_in = 32'h60; tick();
        bus.pc_in = 32'h64; tick();
        bus.pc_valid_in = 1'b0;
        bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h60606060; tick();
        bus.imem_rsp_valid_in = 1'b0;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b1 || bus.fetch_ready_out !== 1'b0)
            begin n_fail++; $display("FAIL rm_before: got v=%b rdy=%b want 1 0", bus.instr_valid_out, bus.fetch_ready_out); end
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        #1;
        n_chk++; if (bus.instr_valid_out !== 1'b0 || bus.instr_out !== 32'h0 || bus.fetch_ready_out !== 1'b1)
            begin n_fail++; $display("FAIL rm_after: got v=%b i=%h rdy=%b want 0 0 1", bus.instr_valid_out, bus.instr_out, bus.fetch_ready_out); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_credit();
        test_flush();
        test_flush_with_rsp();
        test_flush_buffered();
        test_misalign();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
